intf_slot_writer: RTL and testbench
===================================

Name: intf_slot_writer

Overview:
- Writer end of the per-slot interface array used by our generate-loop interface tests. Consumers sit one per slot and only read `val`; this block is the producer that drives them.
- Accepts write requests on a valid/ready stream and drives `val` onto one addressed slot, or onto all slots (broadcast).
- Holds `vld` on each target slot until that slot's consumer acknowledges.
- Sits in the top of the test harness; consumers attach one per slot through a flattened interface-array connection.

Parameters:
- NUM_SLOTS, 2, number of interface slots driven (1..16).
- DATA_W, 8, width of each slot's `val`.
- PARAM, 1, tag value copied to the `slot_param` output (mirrors the interface parameter).
- TIMEOUT, 15, maximum wait for acks in WAIT_ACK before abort (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_idx  in  4  target slot; 4'hF = broadcast to all slots.
- req_data  in  DATA_W  value to write.
- slot_val  out  NUM_SLOTS*DATA_W  per-slot `val`; slot k occupies bits [k*DATA_W +: DATA_W].
- slot_vld  out  NUM_SLOTS  per-slot new-value strobe, held until acked.
- slot_ack  in  NUM_SLOTS  per-slot consumer acknowledge.
- slot_param  out  8  constant PARAM[7:0].
- busy  out  1  FSM not in IDLE.
- err_idx  out  1  sticky: request addressed a slot >= NUM_SLOTS (and was not broadcast).
- err_tmo  out  1  sticky: ack timeout occurred.
- err_clr  in  1  synchronous clear of err_idx and err_tmo.
- done_cnt  out  16  completed writes, wraps at 16'hFFFF to 0.

Behaviour:
- Reset (async assert, sync release):
  - slot_val=0, slot_vld=0, FSM=IDLE.
  - req_ready=1 after release; err_idx=0, err_tmo=0, done_cnt=0.
- States: IDLE, DRIVE, WAIT_ACK.
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid, capture req_idx and req_data.
  - Broadcast (idx==4'hF): target mask = all ones, go to DRIVE.
  - idx < NUM_SLOTS: mask = one-hot(idx), go to DRIVE.
  - Otherwise: set err_idx, drop the request, stay in IDLE. Slot outputs are unchanged and done_cnt is not incremented.
- DRIVE (exactly 1 cycle, req_ready=0):
  - slot_val of every masked slot <= data.
  - slot_vld of every masked slot <= 1.
  - pending mask <= target mask; timeout counter <= 0.
  - Go to WAIT_ACK.
- Latency: request accepted at edge N; slot_val and slot_vld are visible after edge N+1.
- WAIT_ACK:
  - For each slot with pending=1 and slot_ack=1, clear its pending bit and slot_vld at the next edge.
  - Acks on unmasked or already-cleared slots are ignored.
  - When every pending bit has been cleared (including same-cycle acks): done_cnt+1, go to IDLE. The next request can be accepted the cycle after.
  - Otherwise the counter increments. When it reaches TIMEOUT with bits still pending: clear all slot_vld, set err_tmo, do not increment done_cnt, go to IDLE.
- slot_val persists after completion or timeout; only a new write to that slot changes it.
- Minimum request cycle is 3 clocks (IDLE, DRIVE, WAIT_ACK with immediate ack).
- err_clr:
  - Clears the stickies at the next edge.
  - If a set event happens in the same cycle, the set wins.
- Reset mid-operation returns to reset values immediately; a pending write is lost.
- busy = (state != IDLE).

Decomposition:
- Package intf_slot_pkg:
  - state enum {IDLE, DRIVE, WAIT_ACK}.
  - localparam BCAST_IDX = 4'hF.
  - function onehot_mask(idx, n).
- Sub-module intf_slot_reg (one per slot, generate loop). It holds slot_val/slot_vld/pending, takes load, data and ack, and outputs pending. The top keeps the FSM, timeout counter, errors and done_cnt.

Test Plan:
- Reset release, req idx=0 data=8'hA5, slot_ack[0] one cycle after vld -> slot_val[7:0]=A5, slot_vld=2'b01 for 1 cycle, done_cnt=1, slot 1 untouched at 0.
- Broadcast idx=F data=8'h3C, ack slot1 at cycle+1 and slot0 at cycle+3 -> both val=3C; vld[1] drops first; done_cnt increments once, only after slot0's ack.
- idx=5 with NUM_SLOTS=2 -> err_idx=1, req_ready stays 1, slots unchanged; err_clr pulse -> err_idx=0.
- idx=1 data=8'h77, no ack -> err_tmo=1 after TIMEOUT=15 WAIT_ACK cycles, slot_vld=0, slot_val[15:8]=77, done_cnt unchanged.
- Back-to-back: req_valid held with 4 requests and immediate acks -> each accepted every 3 cycles, done_cnt=4; rst_n pulled low during WAIT_ACK -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/intf_slot_pkg.sv
// Shared types and helpers for the per-slot interface writer.
// Holds the FSM state enum, the broadcast index and the one-hot decode.
package intf_slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT_ACK
    } state_e;

    localparam logic [3:0] BCAST_IDX = 4'hF;
    localparam int         MAX_SLOTS = 16;

    // Returns all-zero for an index outside the first n slots.
    function automatic logic [MAX_SLOTS-1:0] onehot_mask(input logic [3:0] idx, input int n);
        logic [MAX_SLOTS-1:0] m;
        m = '0;
        if (int'(idx) < n) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/intf_slot_reg.sv
// One interface slot: holds its value and a new-value strobe that doubles as
// the pending flag, set on load and cleared by ack or abort.
module intf_slot_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] val_o,
    output logic              vld_o,
    output logic              pending_o
);

    logic [DATA_W-1:0] val_q, val_d;
    logic              pend_q, pend_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        val_d  = val_q;
        pend_d = pend_q;
        if (load_i) begin
            val_d  = data_i;
            pend_d = 1'b1;
        end else if (abort_i || ack_i) begin
            pend_d = 1'b0;
        end
    end

    assign val_o     = val_q;
    assign vld_o     = pend_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/intf_slot_writer.sv
// Producer for the per-slot interface array: writes one slot or broadcasts,
// then waits for every targeted consumer to acknowledge or times out.
module intf_slot_writer
    import intf_slot_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int DATA_W    = 8,
    parameter int PARAM     = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [3:0]                  req_idx_i,
    input  logic [DATA_W-1:0]           req_data_i,
    output logic [NUM_SLOTS*DATA_W-1:0] slot_val_o,
    output logic [NUM_SLOTS-1:0]        slot_vld_o,
    input  logic [NUM_SLOTS-1:0]        slot_ack_i,
    output logic [7:0]                  slot_param_o,
    output logic                        busy_o,
    output logic                        err_idx_o,
    output logic                        err_tmo_o,
    input  logic                        err_clr_i,
    output logic [15:0]                 done_cnt_o
);

    state_e                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [7:0]             tmo_q, tmo_d;
    logic [15:0]            done_q, done_d;
    logic                   err_idx_q, err_idx_d;
    logic                   err_tmo_q, err_tmo_d;
    logic                   err_idx_set, err_tmo_set;
    logic                   load, abort;
    logic [NUM_SLOTS-1:0]   pending;
    logic [MAX_SLOTS-1:0]   req_onehot;

    assign req_onehot = onehot_mask(req_idx_i, NUM_SLOTS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            data_q    <= '0;
            tmo_q     <= '0;
            done_q    <= '0;
            err_idx_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            err_idx_q <= err_idx_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        data_d      = data_q;
        tmo_d       = tmo_q;
        done_d      = done_q;
        err_idx_set = 1'b0;
        err_tmo_set = 1'b0;
        load        = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_idx_i == BCAST_IDX) begin
                        mask_d  = '1;
                        data_d  = req_data_i;
                        state_d = DRIVE;
                    end else if (req_onehot != '0) begin
                        mask_d  = req_onehot[NUM_SLOTS-1:0];
                        data_d  = req_data_i;
                        state_d = DRIVE;
                    end else begin
                        err_idx_set = 1'b1;
                    end
                end
            end
            DRIVE: begin
                load    = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Completion wins over timeout when the last ack lands on the final cycle.
                if ((pending & ~slot_ack_i) == '0) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    abort       = 1'b1;
                    err_tmo_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_idx_d = err_idx_set | (err_idx_q & ~err_clr_i);
        err_tmo_d = err_tmo_set | (err_tmo_q & ~err_clr_i);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            intf_slot_reg #(
                .DATA_W(DATA_W)
            ) u_slot (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .load_i   (load & mask_q[gi]),
                .abort_i  (abort),
                .ack_i    (slot_ack_i[gi] && (state_q == WAIT_ACK)),
                .data_i   (data_q),
                .val_o    (slot_val_o[gi*DATA_W +: DATA_W]),
                .vld_o    (slot_vld_o[gi]),
                .pending_o(pending[gi])
            );
        end
    endgenerate

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign slot_param_o = PARAM[7:0];
    assign err_idx_o    = err_idx_q;
    assign err_tmo_o    = err_tmo_q;
    assign done_cnt_o   = done_q;

endmodule

// File: tb/tb_intf_slot_writer.sv
// Bench for intf_slot_writer: directed vector table, corner-case sequences
// and random transactions checked against a transaction-level model.
module tb_intf_slot_writer;

    localparam int NS    = 2;
    localparam int DW    = 8;
    localparam int TMO   = 15;
    localparam int NEVER = 1000;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_idx;
    logic [DW-1:0]    req_data;
    logic [NS*DW-1:0] slot_val;
    logic [NS-1:0]    slot_vld;
    logic [NS-1:0]    slot_ack;
    logic [7:0]       slot_param;
    logic             busy;
    logic             err_idx;
    logic             err_tmo;
    logic             err_clr;
    logic [15:0]      done_cnt;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Model state
    logic [7:0] exp_val [NS];
    int         exp_done;
    logic       exp_err_idx;
    logic       exp_err_tmo;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] data;
        int         d0;
        int         d1;
        int         kind; // 0 complete, 1 timeout, 2 bad index
    } vec_t;

    vec_t vecs [9];

    intf_slot_writer #(
        .NUM_SLOTS(NS),
        .DATA_W   (DW),
        .PARAM    (1),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_idx_i   (req_idx),
        .req_data_i  (req_data),
        .slot_val_o  (slot_val),
        .slot_vld_o  (slot_vld),
        .slot_ack_i  (slot_ack),
        .slot_param_o(slot_param),
        .busy_o      (busy),
        .err_idx_o   (err_idx),
        .err_tmo_o   (err_tmo),
        .err_clr_i   (err_clr),
        .done_cnt_o  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_slots(input string name);
        for (int i = 0; i < NS; i++) begin
            chk(name, 32'(slot_val[i*DW +: DW]), 32'(exp_val[i]));
        end
    endtask

    task automatic chk_status(input string name);
        chk({name, "_done"}, 32'(done_cnt), 32'(exp_done[15:0]));
        chk({name, "_erridx"}, 32'(err_idx), 32'(exp_err_idx));
        chk({name, "_errtmo"}, 32'(err_tmo), 32'(exp_err_tmo));
    endtask

    function automatic int outcome(input logic [3:0] idx, input int d0, input int d1);
        int m;
        if (idx != 4'hF && int'(idx) >= NS) return 2;
        if (idx == 4'hF) m = (d0 > d1) ? d0 : d1;
        else if (idx == 4'd0) m = d0;
        else m = d1;
        return (m <= TMO - 1) ? 0 : 1;
    endfunction

    // One write with per-slot ack delays, counted in WAIT_ACK cycles after vld appears.
    task automatic do_txn(input logic [3:0] idx, input logic [7:0] data,
                          input int d0, input int d1, input int kind);
        logic [NS-1:0] mask;
        logic [NS-1:0] exp_vld;
        logic [NS-1:0] remain;
        int dl [NS];
        int w;
        dl[0] = d0;
        dl[1] = d1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_idx   = idx;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        if (kind == 2) begin
            exp_err_idx = 1'b1;
            chk("badidx_busy", 32'(busy), 32'd0);
            chk("badidx_ready", 32'(req_ready), 32'd1);
            chk("badidx_vld", 32'(slot_vld), 32'd0);
            chk_slots("badidx_val");
            chk_status("badidx");
        end else begin
            mask = (idx == 4'hF) ? {NS{1'b1}} : NS'(1 << idx);
            chk("drive_busy", 32'(busy), 32'd1);
            chk("drive_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            for (int i = 0; i < NS; i++) if (mask[i]) exp_val[i] = data;
            for (int k = 0; k < TMO; k++) begin
                for (int i = 0; i < NS; i++) begin
                    exp_vld[i]  = mask[i] && (dl[i] >= k);
                    remain[i]   = mask[i] && (dl[i] > k);
                    slot_ack[i] = (dl[i] == k);
                end
                chk("wait_vld", 32'(slot_vld), 32'(exp_vld));
                chk("wait_busy", 32'(busy), 32'd1);
                chk_slots("wait_val");
                @(negedge clk);
                slot_ack = '0;
                if (remain == '0) break;
            end
            if (kind == 0) exp_done++;
            else exp_err_tmo = 1'b1;
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_vld", 32'(slot_vld), 32'd0);
            chk_slots("end_val");
            chk_status("end");
        end
        $display("txn %0d: idx=%h data=%h d0=%0d d1=%0d kind=%0d done=%0d err_idx=%0d err_tmo=%0d",
                 txn_no, idx, data, d0, d1, kind, done_cnt, err_idx, err_tmo);
        txn_no++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) exp_val[i] = '0;
        exp_done    = 0;
        exp_err_idx = 1'b0;
        exp_err_tmo = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr     = 1'b0;
        exp_err_idx = 1'b0;
        exp_err_tmo = 1'b0;
        chk_status("errclr");
        $display("txn %0d: err_clr pulse err_idx=%0d err_tmo=%0d", txn_no, err_idx, err_tmo);
        txn_no++;
    endtask

    initial begin
        int acc;
        int acc_cyc [4];
        int c;
        logic [3:0] ridx;
        logic [7:0] rdata;
        int rd0, rd1;

        vecs[0] = '{idx: 4'h0, data: 8'hA5, d0: 0,     d1: NEVER, kind: 0};
        vecs[1] = '{idx: 4'hF, data: 8'h3C, d0: 3,     d1: 1,     kind: 0};
        vecs[2] = '{idx: 4'h5, data: 8'hDE, d0: 0,     d1: 0,     kind: 2};
        vecs[3] = '{idx: 4'h1, data: 8'h77, d0: NEVER, d1: NEVER, kind: 1};
        vecs[4] = '{idx: 4'h1, data: 8'h11, d0: NEVER, d1: 14,    kind: 0};
        vecs[5] = '{idx: 4'h0, data: 8'h22, d0: 15,    d1: 0,     kind: 1};
        vecs[6] = '{idx: 4'hF, data: 8'h99, d0: 0,     d1: 0,     kind: 0};
        vecs[7] = '{idx: 4'h0, data: 8'h44, d0: 2,     d1: 0,     kind: 0};
        vecs[8] = '{idx: 4'hE, data: 8'h55, d0: 0,     d1: 0,     kind: 2};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_idx   = '0;
        req_data  = '0;
        slot_ack  = '0;
        err_clr   = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_val", 32'(slot_val), 32'd0);
        chk("rst_vld", 32'(slot_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_status("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'd1);
        chk("param", 32'(slot_param), 32'd1);

        for (int v = 0; v < 9; v++) begin
            do_txn(vecs[v].idx, vecs[v].data, vecs[v].d0, vecs[v].d1, vecs[v].kind);
            if (v == 2 || v == 3) pulse_clr();
        end

        // Set beats clear in the same cycle.
        req_valid = 1'b1;
        req_idx   = 4'h7;
        err_clr   = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
        err_clr     = 1'b0;
        exp_err_idx = 1'b1;
        exp_err_tmo = 1'b0;
        chk_status("setwins");
        $display("txn %0d: bad idx with err_clr err_idx=%0d", txn_no, err_idx);
        txn_no++;
        pulse_clr();

        // Back-to-back with req_valid held and slot 0 acking continuously.
        slot_ack = 2'b01;
        acc = 0;
        c   = 0;
        while (c < 40) begin
            if (req_ready) begin
                if (acc == 4) begin
                    req_valid = 1'b0;
                    break;
                end
                req_valid    = 1'b1;
                req_idx      = 4'h0;
                req_data     = 8'h50 + 8'(acc);
                acc_cyc[acc] = c;
                acc++;
            end
            @(negedge clk);
            c++;
        end
        req_valid = 1'b0;
        slot_ack  = '0;
        chk("b2b_accepts", 32'(acc), 32'd4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        exp_done  += 4;
        exp_val[0] = 8'h53;
        chk_slots("b2b_val");
        chk_status("b2b");
        $display("txn %0d: back-to-back x4 done=%0d", txn_no, done_cnt);
        txn_no++;

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ridx = 4'h0;
                4, 5, 6:    ridx = 4'h1;
                7, 8:       ridx = 4'hF;
                default:    ridx = 4'($urandom_range(2, 14));
            endcase
            rdata = 8'($urandom_range(0, 255));
            rd0 = $urandom_range(0, 17);
            rd1 = $urandom_range(0, 17);
            do_txn(ridx, rdata, rd0, rd1, outcome(ridx, rd0, rd1));
            if ($urandom_range(0, 4) == 0) pulse_clr();
        end

        // Asynchronous reset while waiting for an ack.
        req_valid = 1'b1;
        req_idx   = 4'h1;
        req_data  = 8'hEE;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_vld", 32'(slot_vld), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_val", 32'(slot_val), 32'd0);
        chk("arst_vld", 32'(slot_vld), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk_status("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", 32'(req_ready), 32'd1);
        $display("txn %0d: async reset during WAIT_ACK", txn_no);
        txn_no++;
        do_txn(4'h0, 8'h5A, 1, NEVER, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
